// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: default address map and next-PC source encoding.
package mips_pkg;

  localparam int unsigned AW_DEF        = 32;
  localparam int unsigned RAS_DEPTH_DEF = 4;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_4180;

  typedef enum logic [2:0] {
    NPC_EXC,
    NPC_HOLD,
    NPC_RAS,
    NPC_REDIR,
    NPC_SEQ
  } npc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned DW    = 30,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] push_data_i,
  output logic [DW-1:0] top_o,
  output logic          empty_o
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = PTRW + 1;

  logic [DW-1:0]   mem_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, top_ptr, wr_slot;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            full, do_pop;

  assign top_ptr = wr_ptr_q - PTRW'(1);
  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CNTW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign top_o   = mem_q[top_ptr];
  // Pop+push replaces the current top in place.
  assign wr_slot = do_pop ? top_ptr : wr_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_pop && !push_i) begin
      wr_ptr_d = top_ptr;
      cnt_d    = cnt_q - CNTW'(1);
    end else if (push_i && !do_pop) begin
      wr_ptr_d = wr_ptr_q + PTRW'(1);
      if (!full) cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_slot] <= push_data_i;
  end

endmodule

// File: rtl/pc_gen.sv
// Program counter with exception, RAS-predicted return, redirect and sequential next-PC selection.
module pc_gen
  import mips_pkg::*;
#(
  parameter int unsigned    AW        = AW_DEF,
  parameter logic [AW-1:0]  RESET_VEC = AW'(RESET_VEC_DEF),
  parameter logic [AW-1:0]  EXC_VEC   = AW'(EXC_VEC_DEF),
  parameter int unsigned    RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          pc_wr_i,
  input  logic          exc_valid_i,
  input  logic          redirect_valid_i,
  input  logic [AW-3:0] redirect_pc_i,
  input  logic          call_i,
  input  logic          ret_i,
  input  logic          fetch_ready_i,
  output logic          fetch_valid_o,
  output logic [AW-3:0] pc_o,
  output logic [AW-3:0] epc_o,
  output logic          ras_empty_o
);

  localparam int unsigned PW = AW - 2;

  logic [PW-1:0] pc_q, pc_d, epc_q, epc_d, seq, ras_top;
  logic          fetch_valid_q, xfer, ras_push, ras_pop;
  npc_src_e      npc_src;

  assign xfer = fetch_valid_q & fetch_ready_i;
  assign seq  = pc_q + PW'(1);

  pc_ras #(
    .DW    (PW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (seq),
    .top_o       (ras_top),
    .empty_o     (ras_empty_o)
  );

  // Exception beats stall; stall beats any redirect; redirects win even without a transfer.
  always_comb begin
    npc_src  = NPC_HOLD;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (exc_valid_i) begin
      npc_src = NPC_EXC;
    end else if (!pc_wr_i) begin
      npc_src = NPC_HOLD;
    end else if (redirect_valid_i) begin
      ras_push = call_i;
      if (ret_i && !ras_empty_o) begin
        npc_src = NPC_RAS;
        ras_pop = 1'b1;
      end else begin
        npc_src = NPC_REDIR;
      end
    end else if (xfer) begin
      npc_src = NPC_SEQ;
    end
  end

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    case (npc_src)
      NPC_EXC: begin
        pc_d  = EXC_VEC[AW-1:2];
        epc_d = pc_q;
      end
      NPC_RAS:   pc_d = ras_top;
      NPC_REDIR: pc_d = redirect_pc_i;
      NPC_SEQ:   pc_d = seq;
      default:   pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= RESET_VEC[AW-1:2];
      epc_q         <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      fetch_valid_q <= 1'b1;
    end
  end

  assign pc_o          = pc_q;
  assign epc_o         = epc_q;
  assign fetch_valid_o = fetch_valid_q;

endmodule
